// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch, divide wait and exception/ERET flush.
// Optional PIPE_HAZARD_PERF_EN adds saturating stall_cycles / flush_cycles counters.
module pipe_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int DIV_MAX      = 40
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rs,
   input  logic       id_uses_rt,
   input  logic       ex_memread,
   input  logic [4:0] ex_rt,
   input  logic       ex_branch_taken,
   input  logic       div_start,
   input  logic       div_done,
   input  logic       exc_req,
   input  logic       eret_req,
   output logic       pc_stall,
   output logic       ifid_stall,
   output logic       ifid_flush,
   output logic       idex_bubble,
   output logic       idex_flush,
   output logic       idex_stall,
   output logic       exmem_flush,
   output logic [1:0] pc_sel,
   output logic       div_abort,
   output logic       div_timeout,
   output logic [1:0] state_o
`ifdef PIPE_HAZARD_PERF_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_cycles
`endif
);

   typedef enum logic [1:0] {
      RUN       = 2'b00,
      DIV_WAIT  = 2'b01,
      EXC_FLUSH = 2'b10
   } state_t;

   localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
   localparam logic [7:0] DIV_LAST   = 8'(DIV_MAX - 1);

   state_t     state, state_nxt;
   logic [3:0] fcnt, fcnt_nxt;
   logic [7:0] dcnt, dcnt_nxt;
   logic       load_use;
   logic       exc_evt;

   assign load_use = ex_memread && (ex_rt != 5'd0) &&
                     ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
   assign exc_evt  = exc_req || eret_req;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         fcnt  <= 4'd0;
         dcnt  <= 8'd0;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
         dcnt  <= dcnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      fcnt_nxt    = fcnt;
      dcnt_nxt    = dcnt;
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      idex_flush  = 1'b0;
      idex_stall  = 1'b0;
      exmem_flush = 1'b0;
      pc_sel      = 2'b00;
      div_abort   = 1'b0;
      div_timeout = 1'b0;
      state_o     = 2'b00;
      // Outputs stay quiet for the whole reset cycle, even before state has returned to RUN.
      if (!reset) begin
         state_o = state;
         case (state)
            RUN: begin
               if (exc_evt) begin
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_flush = 1'b1;
                  pc_sel      = exc_req ? 2'b10 : 2'b11;
                  state_nxt   = EXC_FLUSH;
                  fcnt_nxt    = FLUSH_INIT;
               end else if (ex_branch_taken) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  pc_sel     = 2'b01;
               end else if (div_start) begin
                  state_nxt = DIV_WAIT;
                  dcnt_nxt  = 8'd0;
               end else if (load_use) begin
                  pc_stall    = 1'b1;
                  ifid_stall  = 1'b1;
                  idex_bubble = 1'b1;
               end
            end
            DIV_WAIT: begin
               if (exc_evt) begin
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_flush = 1'b1;
                  pc_sel      = exc_req ? 2'b10 : 2'b11;
                  div_abort   = 1'b1;
                  state_nxt   = EXC_FLUSH;
                  fcnt_nxt    = FLUSH_INIT;
               end else if (div_done) begin
                  state_nxt = RUN;
               end else if (dcnt == DIV_LAST) begin
                  div_timeout = 1'b1;
                  state_nxt   = RUN;
               end else begin
                  pc_stall    = 1'b1;
                  ifid_stall  = 1'b1;
                  idex_stall  = 1'b1;
                  exmem_flush = 1'b1;
                  dcnt_nxt    = dcnt + 8'd1;
               end
            end
            EXC_FLUSH: begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               if (fcnt == 4'd0) state_nxt = RUN;
               else              fcnt_nxt  = fcnt - 4'd1;
            end
            default: state_nxt = RUN;
         endcase
      end
   end

`ifdef PIPE_HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= 32'd0;
         flush_cycles <= 32'd0;
      end else begin
         if (pc_stall && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
         if (ifid_flush && (flush_cycles != 32'hFFFF_FFFF)) flush_cycles <= flush_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: fixed vector table, directed multi-cycle sequences and random stimulus
// checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

   localparam int FLUSH_CYCLES = 2;
   localparam int DIV_MAX      = 40;

   typedef struct packed {
      logic       reset;
      logic [4:0] id_rs;
      logic [4:0] id_rt;
      logic       uses_rs;
      logic       uses_rt;
      logic       memread;
      logic [4:0] ex_rt;
      logic       branch;
      logic       div_start;
      logic       div_done;
      logic       exc;
      logic       eret;
   } in_t;

   typedef struct {
      in_t         i;
      logic [12:0] e;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rs, id_uses_rt, ex_memread, ex_branch_taken;
   logic       div_start, div_done, exc_req, eret_req;
   logic       pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_flush, idex_stall, exmem_flush;
   logic [1:0] pc_sel, state_o;
   logic       div_abort, div_timeout;
`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] stall_cycles, flush_cycles;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // model state: in a divide wait, cycles already stalled there, flush cycles still owed
   bit in_div       = 1'b0;
   int div_elapsed  = 0;
   int flush_left   = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .DIV_MAX(DIV_MAX)) dut (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
      .div_start(div_start), .div_done(div_done), .exc_req(exc_req), .eret_req(eret_req),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .idex_flush(idex_flush), .idex_stall(idex_stall),
      .exmem_flush(exmem_flush), .pc_sel(pc_sel), .div_abort(div_abort),
      .div_timeout(div_timeout), .state_o(state_o)
`ifdef PIPE_HAZARD_PERF_EN
      , .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
`endif
   );

   // {state, pc_sel, pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_flush, idex_stall, exmem_flush, div_abort, div_timeout}
   function automatic logic [12:0] pack_outs();
      return {state_o, pc_sel, pc_stall, ifid_stall, ifid_flush, idex_bubble,
              idex_flush, idex_stall, exmem_flush, div_abort, div_timeout};
   endfunction

   function automatic in_t idle();
      in_t v;
      v = '0;
      return v;
   endfunction

   function automatic in_t lu(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                              input logic urt, input logic mr, input logic [4:0] ert, input logic br);
      in_t v;
      v = '0;
      v.id_rs = rs; v.id_rt = rt; v.uses_rs = urs; v.uses_rt = urt;
      v.memread = mr; v.ex_rt = ert; v.branch = br;
      return v;
   endfunction

   task automatic drive(input in_t v);
      reset = v.reset; id_rs = v.id_rs; id_rt = v.id_rt;
      id_uses_rs = v.uses_rs; id_uses_rt = v.uses_rt;
      ex_memread = v.memread; ex_rt = v.ex_rt; ex_branch_taken = v.branch;
      div_start = v.div_start; div_done = v.div_done; exc_req = v.exc; eret_req = v.eret;
   endtask

   task automatic model(input in_t v, output logic [12:0] e);
      bit hazard;
      e = '0;
      if (v.reset) begin
         in_div = 1'b0; div_elapsed = 0; flush_left = 0;
         return;
      end
      hazard = v.memread && (v.ex_rt != 0) &&
               ((v.uses_rs && v.id_rs == v.ex_rt) || (v.uses_rt && v.id_rt == v.ex_rt));
      e[12:11] = (flush_left > 0) ? 2'b10 : (in_div ? 2'b01 : 2'b00);
      if (flush_left > 0) begin
         e[6] = 1'b1; e[4] = 1'b1;
         flush_left--;
      end else if (v.exc || v.eret) begin
         e[6] = 1'b1; e[4] = 1'b1; e[2] = 1'b1;
         e[10:9] = v.exc ? 2'b10 : 2'b11;
         e[1] = in_div;
         in_div = 1'b0;
         flush_left = FLUSH_CYCLES;
      end else if (in_div) begin
         if (v.div_done) begin
            in_div = 1'b0;
         end else if (div_elapsed == DIV_MAX - 1) begin
            e[0] = 1'b1;
            in_div = 1'b0;
         end else begin
            e[8] = 1'b1; e[7] = 1'b1; e[3] = 1'b1; e[2] = 1'b1;
            div_elapsed++;
         end
      end else if (v.branch) begin
         e[10:9] = 2'b01; e[6] = 1'b1; e[4] = 1'b1;
      end else if (v.div_start) begin
         in_div = 1'b1; div_elapsed = 0;
      end else if (hazard) begin
         e[8] = 1'b1; e[7] = 1'b1; e[5] = 1'b1;
      end
   endtask

   task automatic cycle(input in_t v, input string name, input bit use_tab,
                        input logic [12:0] tab, output logic [12:0] got);
      logic [12:0] e;
      @(negedge clk);
      drive(v);
      #1;
      model(v, e);
      if (use_tab) e = tab;
      got = pack_outs();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, got, e);
      end
      cyc++;
   endtask

   task automatic expect_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[8];
      logic [12:0] g;
      in_t         v;
      int          n_st, to_n, to_at;

      tbl[0] = '{idle(),                                  13'b00_00_000000000};
      tbl[1] = '{lu(5'd5, 5'd0, 1, 0, 1, 5'd5, 0),        13'b00_00_110100000};
      tbl[2] = '{lu(5'd0, 5'd0, 1, 0, 1, 5'd0, 0),        13'b00_00_000000000};
      tbl[3] = '{lu(5'd1, 5'd7, 0, 1, 1, 5'd7, 0),        13'b00_00_110100000};
      tbl[4] = '{lu(5'd5, 5'd0, 0, 0, 1, 5'd5, 0),        13'b00_00_000000000};
      tbl[5] = '{lu(5'd5, 5'd5, 1, 1, 0, 5'd5, 0),        13'b00_00_000000000};
      tbl[6] = '{lu(5'd5, 5'd0, 1, 0, 1, 5'd5, 1),        13'b00_01_001010000};
      tbl[7] = '{lu(5'd0, 5'd0, 0, 0, 0, 5'd0, 1),        13'b00_01_001010000};

      drive(idle());
      v = idle(); v.reset = 1'b1;
      cycle(v, "reset", 0, '0, g);
      cycle(v, "reset", 0, '0, g);

      for (int k = 0; k < 8; k++) begin
         cycle(tbl[k].i, $sformatf("table%0d", k), 1, tbl[k].e, g);
         cycle(idle(), "table_gap", 0, '0, g);
      end

      // divide completing after 10 stalled cycles
      v = idle(); v.div_start = 1'b1;
      cycle(v, "div_issue", 0, '0, g);
      n_st = 0;
      for (int k = 0; k < 10; k++) begin
         cycle(idle(), "div_wait", 0, '0, g);
         n_st += int'(g[8]);
      end
      expect_int("div_stall_count", n_st, 10);
      v = idle(); v.div_done = 1'b1;
      cycle(v, "div_done", 0, '0, g);
      cycle(idle(), "div_after", 0, '0, g);

      // divide watchdog
      v = idle(); v.div_start = 1'b1;
      cycle(v, "to_issue", 0, '0, g);
      to_n = 0; to_at = 0; n_st = 0;
      for (int k = 1; k <= 43; k++) begin
         cycle(idle(), "to_wait", 0, '0, g);
         n_st += int'(g[8]);
         if (g[0]) begin to_n++; to_at = k; end
      end
      expect_int("timeout_pulses", to_n, 1);
      expect_int("timeout_cycle", to_at, DIV_MAX);
      expect_int("timeout_stalls", n_st, DIV_MAX - 1);

      // exception in RUN, second exception inside the window
      v = idle(); v.exc = 1'b1;
      cycle(v, "exc_entry", 0, '0, g);
      cycle(v, "exc_ignored", 0, '0, g);
      for (int k = 0; k < 3; k++) cycle(idle(), "exc_tail", 0, '0, g);

      // exception during divide with div_done the same cycle
      v = idle(); v.div_start = 1'b1;
      cycle(v, "xd_issue", 0, '0, g);
      for (int k = 0; k < 3; k++) cycle(idle(), "xd_wait", 0, '0, g);
      v = idle(); v.exc = 1'b1; v.div_done = 1'b1;
      cycle(v, "xd_abort", 0, '0, g);
      expect_int("xd_abort_bit", int'(g[1]), 1);
      for (int k = 0; k < 3; k++) cycle(idle(), "xd_tail", 0, '0, g);

      // ERET alone
      v = idle(); v.eret = 1'b1;
      cycle(v, "eret_entry", 0, '0, g);
      expect_int("eret_pc_sel", int'(g[10:9]), 3);
      for (int k = 0; k < 3; k++) cycle(idle(), "eret_tail", 0, '0, g);

      // reset in the middle of a divide wait
      v = idle(); v.div_start = 1'b1;
      cycle(v, "rd_issue", 0, '0, g);
      for (int k = 0; k < 4; k++) cycle(idle(), "rd_wait", 0, '0, g);
      v = idle(); v.reset = 1'b1;
      cycle(v, "rd_reset", 0, '0, g);
      cycle(idle(), "rd_after", 0, '0, g);
`ifdef PIPE_HAZARD_PERF_EN
      expect_int("stall_cycles_cleared", int'(stall_cycles), 0);
`endif

      // random traffic
      for (int n = 0; n < 2500; n++) begin
         v = '0;
         v.reset     = ($urandom_range(0, 96) == 0);
         v.id_rs     = 5'($urandom_range(0, 7));
         v.id_rt     = 5'($urandom_range(0, 7));
         v.uses_rs   = 1'($urandom_range(0, 1));
         v.uses_rt   = 1'($urandom_range(0, 1));
         v.memread   = 1'($urandom_range(0, 1));
         v.ex_rt     = 5'($urandom_range(0, 7));
         v.branch    = ($urandom_range(0, 9) == 0);
         v.div_start = ($urandom_range(0, 11) == 0);
         v.div_done  = ($urandom_range(0, 7) == 0);
         v.exc       = ($urandom_range(0, 39) == 0);
         v.eret      = ($urandom_range(0, 49) == 0);
         cycle(v, "random", 0, '0, g);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the PC, IF/ID, ID/EXE and EXE/MEM control inputs: load-use bubble, branch flush, multi-cycle divide stall and exception/ERET flush. It sits beside the ID/EXE register and owns its `id_flush` and `id_lw` inputs. It also produces the PC source select.

Parameters:
- FLUSH_CYCLES, 2, number of cycles held in EXC_FLUSH after exception/ERET entry (1..15).
- DIV_MAX, 40, divide watchdog limit in cycles spent in DIV_WAIT (2..255).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt
- ex_memread  in  1  EXE instruction is a load (MemRead != 0)
- ex_rt  in  5  load destination in EXE
- ex_branch_taken  in  1  branch/jump resolved taken in EXE
- div_start  in  1  divide issued in EXE this cycle
- div_done  in  1  divider result valid
- exc_req  in  1  exception raised (EXE/MEM)
- eret_req  in  1  ERET committing
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  clear IF/ID
- idex_bubble  out  1  load-use bubble into ID/EXE (drives `id_lw`)
- idex_flush  out  1  clear ID/EXE (drives `id_flush`)
- idex_stall  out  1  hold ID/EXE
- exmem_flush  out  1  clear EXE/MEM
- pc_sel  out  2  00 seq, 01 branch target, 10 exception vector, 11 EPC
- div_abort  out  1  one-cycle pulse: abandon divide in progress
- div_timeout  out  1  one-cycle pulse: watchdog expired
- state_o  out  2  current FSM state (debug)

Behaviour:
- FSM states: RUN=00, DIV_WAIT=01, EXC_FLUSH=10. Registered state, 4-bit flush counter, 8-bit divide counter.
- Reset: state RUN, counters 0. While reset=1, every output is forced to 0 (pc_sel=00).
- All hazard outputs are combinational (Mealy) from state and inputs, with zero-cycle latency.
- Priority, highest first: exc/eret > branch > divide > load-use.
- Exception or ERET in RUN or DIV_WAIT:
  - Same cycle: ifid_flush=idex_flush=exmem_flush=1; pc_sel=10 for exc, 11 for eret (exc wins if both).
  - Next state EXC_FLUSH with counter=FLUSH_CYCLES-1.
  - If taken from DIV_WAIT, div_abort=1 that cycle.
- EXC_FLUSH:
  - ifid_flush=idex_flush=1, pc_sel=00.
  - exc_req, eret_req, ex_branch_taken, div_start and load-use are all ignored.
  - Counter decrements each cycle; when it is 0, next state is RUN.
  - Total flush window is FLUSH_CYCLES+1 cycles including the entry cycle.
- RUN, branch: ex_branch_taken=1 gives ifid_flush=idex_flush=1 and pc_sel=01. Load-use outputs are suppressed in that cycle.
- RUN, divide: div_start=1 with no higher-priority event gives next state DIV_WAIT, counter cleared. No stall in the issue cycle.
- DIV_WAIT:
  - While div_done=0: pc_stall=ifid_stall=idex_stall=1 and exmem_flush=1 (bubbles downstream); counter increments.
  - div_done=1: all stalls are 0 that cycle, next state RUN.
  - Counter reaching DIV_MAX-1 with div_done=0: div_timeout=1, stalls released that cycle, next state RUN.
  - ex_branch_taken is ignored in DIV_WAIT, because the EXE contents are frozen.
- RUN, load-use:
  - Hazard condition: ex_memread && ex_rt!=0 && ((id_uses_rs && id_rs==ex_rt) || (id_uses_rt && id_rt==ex_rt)).
  - Response: pc_stall=ifid_stall=idex_bubble=1.
  - It is self-clearing after one cycle, because EXE then holds a bubble.
- ex_rt=0 never causes a stall.
- Simultaneous div_done and exc_req in DIV_WAIT: the exception wins and div_abort=1.
- Reset mid-DIV_WAIT or mid-EXC_FLUSH: back to RUN next edge, no pulses.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_cycles[31:0].
  - stall_cycles increments on any cycle with pc_stall=1.
  - flush_cycles increments on any cycle with ifid_flush=1.
  - Both cleared by reset; both saturate at 0xFFFFFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Load-use: ex_memread=1, ex_rt=5, id_rs=5, id_uses_rs=1 -> pc_stall=ifid_stall=idex_bubble=1 for exactly that cycle. With ex_rt=0, the same stimulus gives all 0.
2. Branch vs load-use: ex_branch_taken=1 with a load-use match -> ifid_flush=idex_flush=1, pc_sel=01, idex_bubble=0.
3. Divide: div_start pulse, div_done after 10 cycles -> state_o=01, pc_stall=1 for 10 cycles, 0 in the div_done cycle, then RUN. With no div_done -> div_timeout pulse at cycle 40, then RUN.
4. Exception: exc_req=1 in RUN, FLUSH_CYCLES=2 -> entry cycle has all three flushes and pc_sel=10; then 2 cycles with ifid/idex flush and pc_sel=00. A second exc_req during the window is ignored.
5. Exception during divide, with div_done asserted the same cycle -> div_abort=1, pc_sel=10, state EXC_FLUSH. ERET alone -> pc_sel=11.
6. Reset asserted in DIV_WAIT -> all outputs 0 during reset, state RUN after. With PIPE_HAZARD_PERF_EN defined, stall_cycles returns to 0.
